// File: rtl/mp_adder_pkg.sv
// Shared definitions for the multi-precision adder: default sizes, limb-count
// helper and the sequencer state type.
package mp_adder_pkg;

    localparam int WIDTH_DEF      = 1027;
    localparam int ADDER_SIZE_DEF = 257;

    // Limbs needed to cover WIDTH+1 result bits (the extra bit holds carry/borrow).
    function automatic int n_limbs(input int width, input int adder_size);
        return (width + adder_size) / adder_size;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mp_adder_slice.sv
// Combinational W-bit adder with carry-in and carry-out; the only carry chain
// in the datapath, reused once per limb.
module mp_adder_slice #(
    parameter int W = 257
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o
);

    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/mp_adder.sv
// Multi-precision add/subtract: operands are latched on start, then processed
// one ADDER_SIZE-bit limb per cycle through a single slice; done pulses once.
module mp_adder
    import mp_adder_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDER_SIZE = ADDER_SIZE_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done
);

    localparam int N_LIMBS = n_limbs(WIDTH, ADDER_SIZE);
    localparam int PAD_W   = N_LIMBS * ADDER_SIZE;
    localparam int CNT_W   = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(N_LIMBS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [PAD_W-1:0]  a_q, a_d;
    logic [PAD_W-1:0]  b_q, b_d;
    logic              done_q, done_d;
    logic              limb_we;
    logic [ADDER_SIZE-1:0] slice_sum;
    logic              slice_carry;
    logic [PAD_W-1:0]  acc;

    // Operands are shifted down each cycle so the slice always sees limb 0.
    mp_adder_slice #(
        .W (ADDER_SIZE)
    ) u_slice (
        .a_i   (a_q[ADDER_SIZE-1:0]),
        .b_i   (b_q[ADDER_SIZE-1:0]),
        .c_i   (carry_q),
        .sum_o (slice_sum),
        .c_o   (slice_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        limb_we = 1'b0;
        if (start) begin
            // Subtraction as A + ~B + 1 over the full padded width.
            a_d     = PAD_W'(in_a);
            b_d     = PAD_W'(in_b) ^ {PAD_W{subtract}};
            carry_d = subtract;
            cnt_d   = '0;
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    limb_we = 1'b1;
                    a_d     = a_q >> ADDER_SIZE;
                    b_d     = b_q >> ADDER_SIZE;
                    carry_d = slice_carry;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_LIMB) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    // Result limbs keep their value until the next operation overwrites them.
    genvar gi;
    generate
        for (gi = 0; gi < N_LIMBS; gi = gi + 1) begin : g_limb
            logic [ADDER_SIZE-1:0] limb_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    limb_q <= '0;
                end else if (limb_we && (cnt_q == CNT_W'(gi))) begin
                    limb_q <= slice_sum;
                end
            end

            assign acc[gi*ADDER_SIZE +: ADDER_SIZE] = limb_q;
        end
    endgenerate

    assign result = acc[WIDTH:0];
    assign done   = done_q;

endmodule

// File: tb/tb_mp_adder.sv
// Self-checking bench for mp_adder: directed table, random pairs against an
// arithmetic reference, and handshake corner sequences.
module tb_mp_adder;

    localparam int W  = 1027;
    localparam int RW = W + 1;
    localparam int LAT = 5;

    typedef logic [W-1:0]  op_t;
    typedef logic [RW-1:0] res_t;

    typedef struct {
        op_t  a;
        op_t  b;
        logic sub;
        res_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    logic start;
    logic subtract;
    op_t  in_a;
    op_t  in_b;
    res_t result;
    logic done;

    int n_cmp = 0;
    int n_bad = 0;

    mp_adder dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input op_t a, input op_t b, input logic sub);
        res_t ea;
        res_t eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return sub ? (ea - eb) : (ea + eb);
    endfunction

    function automatic op_t rand_op();
        op_t r;
        r = '0;
        for (int i = 0; i < 33; i++) begin
            r = (r << 32) | op_t'($urandom);
        end
        return r;
    endfunction

    task automatic check(input string name, input res_t got, input res_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got low=%h top=%h required low=%h top=%h",
                     name, got[127:0], got[RW-1:RW-4], exp[127:0], exp[RW-1:RW-4]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Waits (bounded) for done; returns cycles counted from the sampling edge.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input op_t a, input op_t b, input logic sub,
                          output res_t got, output int lat);
        in_a = a; in_b = b; subtract = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs straight after sampling; result must not follow them.
        in_a = rand_op(); in_b = rand_op(); subtract = ~sub;
        wait_done(lat);
        got = result;
        if (lat > 0) begin
            @(posedge clk); #1;
            check_int("done_one_cycle", int'(done), 0);
        end
    endtask

    vec_t vecs[8];
    op_t  ones_w;
    op_t  x_val;
    res_t got;
    int   lat;
    op_t  a1, b1, a2, b2;
    logic s1, s2;
    int   pulses;

    initial begin
        ones_w = '1;
        x_val  = op_t'(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210) << 700;
        vecs[0] = '{a: op_t'(1000), b: op_t'(2000), sub: 1'b0, exp: res_t'(3000)};
        vecs[1] = '{a: op_t'(3000), b: op_t'(1500), sub: 1'b1, exp: res_t'(1500)};
        vecs[2] = '{a: ones_w,      b: op_t'(1),    sub: 1'b0, exp: res_t'(1) << W};
        vecs[3] = '{a: op_t'(0),    b: x_val,       sub: 1'b0, exp: {1'b0, x_val}};
        vecs[4] = '{a: op_t'(0),    b: op_t'(1),    sub: 1'b1, exp: '1};
        vecs[5] = '{a: x_val,       b: x_val,       sub: 1'b1, exp: '0};
        vecs[6] = '{a: op_t'(1500), b: op_t'(3000), sub: 1'b1, exp: ~res_t'(1499)};
        vecs[7] = '{a: ones_w,      b: ones_w,      sub: 1'b0, exp: {ones_w, 1'b0}};

        resetn = 1'b0; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, '0);
        check_int("reset_done", int'(done), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, got, lat);
            check_int($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_result", i), got, vecs[i].exp);
            $display("txn vec%0d sub=%0d lat=%0d result_low=%h", i, vecs[i].sub, lat, got[63:0]);
        end

        for (int i = 0; i < 24; i++) begin
            a1 = rand_op(); b1 = rand_op(); s1 = i[0];
            if (i % 6 == 5) b1 = a1 ^ op_t'(1);
            run_op(a1, b1, s1, got, lat);
            check_int($sformatf("rand%0d_latency", i), lat, LAT);
            check($sformatf("rand%0d_result", i), got, model(a1, b1, s1));
            $display("txn rand%0d sub=%0d lat=%0d result_low=%h", i, s1, lat, got[63:0]);
        end

        // Restart two cycles into RUN: only the second operation completes.
        a1 = rand_op(); b1 = rand_op(); a2 = rand_op(); b2 = rand_op();
        in_a = a1; in_b = b1; subtract = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_a = a2; in_b = b2; subtract = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; in_a = '0; in_b = '0;
        wait_done(lat);
        check_int("restart_latency", lat, LAT);
        check("restart_result", result, model(a2, b2, 1'b1));
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_int("restart_extra_done", pulses, 0);
        $display("txn restart lat=%0d result_low=%h", lat, result[63:0]);

        // Asynchronous reset in the middle of RUN.
        in_a = rand_op(); in_b = rand_op(); subtract = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("midrun_reset_result", result, '0);
        check_int("midrun_reset_done", int'(done), 0);
        @(posedge clk); @(posedge clk); #2;
        resetn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_int("midrun_reset_no_done", pulses, 0);
        check("midrun_reset_hold", result, '0);
        $display("txn midrun_reset pulses=%0d", pulses);

        // Back-to-back: second start in the done cycle.
        a1 = rand_op(); b1 = rand_op(); s1 = 1'b1;
        a2 = rand_op(); b2 = rand_op(); s2 = 1'b0;
        in_a = a1; in_b = b1; subtract = s1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat);
        check_int("b2b_first_latency", lat, LAT);
        check("b2b_first_result", result, model(a1, b1, s1));
        $display("txn b2b_first lat=%0d result_low=%h", lat, result[63:0]);
        in_a = a2; in_b = b2; subtract = s2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; in_a = '0; in_b = '1;
        wait_done(lat);
        check_int("b2b_second_latency", lat, LAT);
        check("b2b_second_result", result, model(a2, b2, s2));
        $display("txn b2b_second lat=%0d result_low=%h", lat, result[63:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
